regfile_dump_ctrl: RTL and testbench
====================================

// Module: regfile_dump_ctrl
// PURPOSE
//  Debug controller that takes ownership of the register file's read port A and write enable while the pipeline is halted.
//  It sequences reads of all registers and serialises each word as bytes over a valid/ready stream to the UART TX.
//  It sits between the pipeline (decode/writeback) and the register file, and between the register file and the debug unit.
//  When idle it is a transparent pass-through: the pipeline owns the register file unchanged.
// PARAMETERS
//  NUM_REGS  32  registers dumped, index 0..NUM_REGS-1
//  ADDR_W    5   register address width, 2**ADDR_W >= NUM_REGS
//  DATA_W    32  register width; multiple of 8, BYTES = DATA_W/8
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high
//  start        in   1       dump request pulse from debug unit
//  pipe_halted  in   1       pipeline frozen; no writeback in flight
//  pipe_a1_in   in   ADDR_W  pipeline rs address
//  pipe_we_in   in   1       pipeline write enable
//  rf_rd1_in    in   DATA_W  register file port-1 data, registered, valid 1 cycle after address
//  rf_a1_out    out  ADDR_W  to register file A1 (muxed)
//  rf_we_out    out  1       to register file WE3 (gated)
//  tx_data      out  8       byte to UART TX
//  tx_valid     out  1       tx_data valid
//  tx_ready     in   1       UART accepts byte this cycle
//  busy         out  1       dump owns register file (ADDR/LATCH/SEND)
//  done         out  1       1-cycle pulse: full dump completed
//  aborted      out  1       1-cycle pulse: dump cancelled (halt lost)
// BEHAVIOUR
//  Reset values: state=IDLE, idx=0, byte_cnt=0, tx_valid=0, tx_data=0, done=0, aborted=0, busy=0.
//  FSM states: IDLE, WAIT_HALT, ADDR, LATCH, SEND, DONE.
//  IDLE:
//   - start=1 and pipe_halted=1 -> ADDR, idx=0.
//   - start=1 and pipe_halted=0 -> WAIT_HALT.
//   - start ignored in every state except IDLE.
//  WAIT_HALT: -> ADDR (idx=0) on the first cycle pipe_halted=1. Pass-through still active.
//  ADDR: rf_a1_out=idx. -> LATCH.
//  LATCH: rf_rd1_in valid; captured into shift register sh at the clock edge. -> SEND, byte_cnt=0.
//  SEND:
//   - tx_valid=1, tx_data=sh[DATA_W-1 -: 8]; bytes go out MSB first.
//   - On tx_valid&&tx_ready: sh<<=8, byte_cnt++.
//   - After byte BYTES-1 is accepted: idx==NUM_REGS-1 -> DONE; otherwise idx++ and -> ADDR.
//   - tx_data/tx_valid held stable while tx_ready=0; tx_valid never drops before the handshake completes.
//  DONE: done=1 for exactly one cycle. -> IDLE.
//  Muxing (combinational from state):
//   - rf_a1_out = busy ? idx : pipe_a1_in.
//   - rf_we_out = pipe_we_in & ~busy.
//   - Port 2 is not touched.
//  Latency: 2+BYTES cycles per register with tx_ready tied high; 192 cycles plus 1 DONE cycle for the default parameters.
//  Register 0 is dumped as read; no special-casing.
//  Abort: pipe_halted=0 in ADDR/LATCH/SEND -> IDLE on the next edge.
//   - aborted pulses 1 cycle, tx_valid drops, done is not asserted.
//   - A byte mid-handshake is dropped.
//  Reset mid-dump: returns to IDLE in 1 cycle; ports revert to pass-through; no done or aborted pulse.
//  idx/byte_cnt never wrap: the terminal checks occur before increment.
// STRUCTURE
//  Shared package (debug_pkg): state encoding localparams, NUM_REGS, ADDR_W, DATA_W, byte width 8.
//  Sub-module word_serializer: load/valid/ready, DATA_W to 8-bit, MSB first, last-byte flag.
//  The FSM, idx counter and port muxes stay in this module.
// TESTING
//  1. Register k preloaded to 0x01010101*k, reg5=0xDEADBEEF, halted, tx_ready=1, start pulse:
//     -> 128 bytes; bytes 20..23 = DE AD BE EF; done at cycle 193 after start; busy high 192 cycles.
//  2. Same dump with tx_ready toggling 1-in-3:
//     -> identical byte sequence; tx_data stable while tx_valid&&!tx_ready.
//  3. start with pipe_halted=0 for 10 cycles, then 1:
//     -> WAIT_HALT; rf_a1_out follows pipe_a1_in until halt; dump then starts at idx 0.
//  4. Drop pipe_halted during reg 7 SEND:
//     -> aborted pulse next cycle, tx_valid=0, no done, rf_a1_out=pipe_a1_in again.
//  5. pipe_we_in=1 during dump:
//     -> rf_we_out=0 throughout busy; rf_we_out=1 in IDLE.
//  6. reset asserted mid-dump, then start again:
//     -> all outputs at reset values; second dump begins from reg 0 and completes correctly.

Source files
------------

// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared definitions for the register-file dump controller.
// Holds the default geometry (register count, address/data width, byte width),
// the FSM state encoding and a small helper that tells whether a state owns
// the register file read port.
package regfile_dump_ctrl_pkg;

  localparam int RDC_NUM_REGS = 32;
  localparam int RDC_ADDR_W   = 5;
  localparam int RDC_DATA_W   = 32;
  localparam int RDC_BYTE_W   = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_HALT = 3'd1;
  localparam logic [2:0] ST_ADDR      = 3'd2;
  localparam logic [2:0] ST_LATCH     = 3'd3;
  localparam logic [2:0] ST_SEND      = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  // The dump owns the register file only while it is actively reading/sending.
  function automatic logic owns_rf(input logic [2:0] st);
    return (st == ST_ADDR) || (st == ST_LATCH) || (st == ST_SEND);
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl_word_serializer.sv
// Word-to-byte serializer for the dump stream.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_load, i_data   capture a full word (resets the byte counter)
//   i_valid, i_ready handshake; on both high the word shifts left one byte
//   o_byte           current byte, MSB of the word first
//   o_last           current byte is the final byte of the word
module regfile_dump_ctrl_word_serializer
  import regfile_dump_ctrl_pkg::*;
#(
  parameter int DATA_W = RDC_DATA_W,
  parameter int BYTE_W = RDC_BYTE_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_ready,
  output logic [BYTE_W-1:0] o_byte,
  output logic              o_last
);

  localparam int BYTES = DATA_W / BYTE_W;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

  logic [DATA_W-1:0] r_sh;
  logic [CNT_W-1:0]  r_byte_cnt;

  // Shift register and byte counter; counter saturates at the last byte so it never wraps.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sh       <= {DATA_W{1'b0}};
      r_byte_cnt <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_sh       <= i_data;
      r_byte_cnt <= {CNT_W{1'b0}};
    end else if (i_valid && i_ready) begin
      r_sh       <= r_sh << BYTE_W;
      r_byte_cnt <= (r_byte_cnt == LAST_CNT) ? r_byte_cnt : r_byte_cnt + CNT_W'(1);
    end else begin
      r_sh       <= r_sh;
      r_byte_cnt <= r_byte_cnt;
    end
  end

  assign o_byte = r_sh[DATA_W-1 -: BYTE_W];
  assign o_last = (r_byte_cnt == LAST_CNT);

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Register-file dump controller.
// While idle it passes the pipeline's read address and write enable straight
// to the register file. On a start request (once the pipeline is halted) it
// takes over read port A, reads every register in order and streams each word
// MSB byte first over a valid/ready byte interface to the UART transmitter.
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_start                dump request pulse (honoured only when idle)
//   i_pipe_halted          pipeline frozen; losing it mid-dump aborts
//   i_pipe_a1, i_pipe_we   pipeline read address / write enable
//   i_rf_rd1               register file port-1 data, valid 1 cycle after address
//   o_rf_a1, o_rf_we       muxed address / gated write enable to register file
//   o_tx_data, o_tx_valid, i_tx_ready   byte stream to UART TX
//   o_busy                 dump owns the register file
//   o_done, o_aborted      one-cycle completion / cancellation pulses
module regfile_dump_ctrl
  import regfile_dump_ctrl_pkg::*;
#(
  parameter int NUM_REGS = RDC_NUM_REGS,
  parameter int ADDR_W   = RDC_ADDR_W,
  parameter int DATA_W   = RDC_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_pipe_halted,
  input  logic [ADDR_W-1:0] i_pipe_a1,
  input  logic              i_pipe_we,
  input  logic [DATA_W-1:0] i_rf_rd1,
  output logic [ADDR_W-1:0] o_rf_a1,
  output logic              o_rf_we,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              r_aborted;

  logic [2:0] w_state_nxt;
  logic       w_abort;
  logic       w_owns;
  logic       w_send;
  logic       w_last_byte;
  logic       w_word_end;
  logic       w_idx_clr;
  logic       w_idx_inc;

  assign w_owns     = owns_rf(r_state);
  assign w_send     = (r_state == ST_SEND);
  assign w_word_end = w_send && i_tx_ready && w_last_byte;

  // A fresh dump always starts at register 0, whether it began directly or after waiting for halt.
  assign w_idx_clr = ((r_state == ST_IDLE) && i_start && i_pipe_halted) ||
                     ((r_state == ST_WAIT_HALT) && i_pipe_halted);
  // Advance only when the word finished without an abort and the last register is not yet done.
  assign w_idx_inc = w_word_end && i_pipe_halted && (r_idx != LAST_IDX);

  regfile_dump_ctrl_word_serializer #(
    .DATA_W (DATA_W),
    .BYTE_W (8)
  ) u_ser (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (r_state == ST_LATCH),
    .i_data  (i_rf_rd1),
    .i_valid (w_send),
    .i_ready (i_tx_ready),
    .o_byte  (o_tx_data),
    .o_last  (w_last_byte)
  );

  // Next-state decode; losing halt while owning the register file wins over any handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = i_pipe_halted ? ST_ADDR : ST_WAIT_HALT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_HALT: begin
        if (i_pipe_halted) begin
          w_state_nxt = ST_ADDR;
        end else begin
          w_state_nxt = ST_WAIT_HALT;
        end
      end
      ST_ADDR, ST_LATCH: begin
        if (!i_pipe_halted) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end else begin
          w_state_nxt = (r_state == ST_ADDR) ? ST_LATCH : ST_SEND;
        end
      end
      ST_SEND: begin
        if (!i_pipe_halted) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end else if (w_word_end) begin
          w_state_nxt = (r_idx == LAST_IDX) ? ST_DONE : ST_ADDR;
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, register index and abort pulse registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= {ADDR_W{1'b0}};
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_aborted <= w_abort;
      if (w_idx_clr) begin
        r_idx <= {ADDR_W{1'b0}};
      end else if (w_idx_inc) begin
        r_idx <= r_idx + ADDR_W'(1);
      end else begin
        r_idx <= r_idx;
      end
    end
  end

  assign o_busy     = w_owns;
  assign o_tx_valid = w_send;
  assign o_done     = (r_state == ST_DONE);
  assign o_aborted  = r_aborted;
  assign o_rf_a1    = w_owns ? r_idx : i_pipe_a1;
  assign o_rf_we    = i_pipe_we & ~w_owns;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Self-checking bench for regfile_dump_ctrl: a behavioural register file plus
// an expected byte stream built from the register image (MSB first, register
// 0 upward). Timing expectations are derived from the count of accepted bytes.
module tb_regfile_dump_ctrl;

  localparam int NREG   = 32;
  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int NB     = DW / 8;
  localparam int NBYTES = NREG * NB;

  logic          clk;
  logic          reset;
  logic          start;
  logic          pipe_halted;
  logic [AW-1:0] pipe_a1;
  logic [AW-1:0] pipe_a3;
  logic          pipe_we;
  logic [DW-1:0] pipe_wd;
  logic [DW-1:0] rf_rd1;
  logic [AW-1:0] o_rf_a1;
  logic          o_rf_we;
  logic [7:0]    o_tx_data;
  logic          o_tx_valid;
  logic          tx_ready;
  logic          o_busy;
  logic          o_done;
  logic          o_aborted;

  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] img  [NREG];
  logic          preload_en;
  logic [7:0]    got  [NBYTES];

  int n_tests = 0;
  int n_fail  = 0;

  regfile_dump_ctrl dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_start       (start),
    .i_pipe_halted (pipe_halted),
    .i_pipe_a1     (pipe_a1),
    .i_pipe_we     (pipe_we),
    .i_rf_rd1      (rf_rd1),
    .o_rf_a1       (o_rf_a1),
    .o_rf_we       (o_rf_we),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .i_tx_ready    (tx_ready),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_aborted     (o_aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: registered read on port 1, write port 3 gated by the DUT.
  always @(posedge clk) begin
    rf_rd1 <= regs[o_rf_a1];
    if (preload_en) begin
      for (int k = 0; k < NREG; k++) regs[k] <= img[k];
    end else if (o_rf_we) begin
      regs[pipe_a3] <= pipe_wd;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got_v, exp_v, $time);
    end
  endtask

  // Called just after a negedge; returns just after the next negedge.
  task automatic preload(input bit spec_pat);
    for (int k = 0; k < NREG; k++) begin
      img[k] = spec_pat ? 32'(32'h0101_0101 * k) : $urandom;
    end
    if (spec_pat) img[5] = 32'hDEAD_BEEF;
    pipe_we    = 1'b0;
    preload_en = 1'b1;
    @(negedge clk);
    preload_en = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start   = 1'b0;
      pipe_a1 = AW'($urandom);
      pipe_a3 = AW'($urandom);
      pipe_wd = $urandom;
      pipe_we = 1'b1;
      #1;
      chk_eq("idle_rf_a1", 32'(o_rf_a1), 32'(pipe_a1));
      chk_eq("idle_rf_we", 32'(o_rf_we), 32'd1);
      chk_eq("idle_busy", 32'(o_busy), 32'd0);
      chk_eq("idle_tx_valid", 32'(o_tx_valid), 32'd0);
    end
    pipe_we = 1'b0;
  endtask

  // kill_mode: 0 none, 1 drop halt, 2 reset -- at first SEND cycle of kill_reg.
  task automatic run_dump(input bit do_start, input int ready_mode, input int kill_mode,
                          input int kill_reg, input bit chk_timing);
    logic [7:0] exp_q[$];
    logic [7:0] prev_data;
    int  cyc, acc, busy_cnt, last_acc_cyc;
    bit  prev_stall, killed, fin, rdy, exp_busy;
    cyc = 0; acc = 0; busy_cnt = 0; last_acc_cyc = -1;
    prev_stall = 1'b0; killed = 1'b0; fin = 1'b0; prev_data = 8'h00;
    for (int k = 0; k < NREG; k++)
      for (int b = NB - 1; b >= 0; b--) exp_q.push_back(img[k][8*b +: 8]);
    pipe_we     = 1'b0;
    pipe_halted = 1'b1;
    tx_ready    = 1'b1;
    start       = do_start;
    @(posedge clk);
    #1 start = 1'b0;
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      pipe_a1 = AW'($urandom);
      pipe_a3 = AW'($urandom);
      pipe_wd = $urandom;
      pipe_we = 1'($urandom);
      if (killed) begin
        start = 1'b0;
        #1;
        if (kill_mode == 1) begin
          chk_eq("abort_pulse", 32'(o_aborted), 32'd1);
        end else begin
          chk_eq("rst_aborted", 32'(o_aborted), 32'd0);
          chk_eq("rst_tx_data", 32'(o_tx_data), 32'd0);
          chk_eq("rst_rf_we", 32'(o_rf_we), 32'(pipe_we));
        end
        chk_eq("kill_tx_valid", 32'(o_tx_valid), 32'd0);
        chk_eq("kill_busy", 32'(o_busy), 32'd0);
        chk_eq("kill_done", 32'(o_done), 32'd0);
        chk_eq("kill_rf_a1", 32'(o_rf_a1), 32'(pipe_a1));
        chk_eq("kill_bytes", 32'(acc), 32'(kill_reg * NB));
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk_eq("kill_aborted_clr", 32'(o_aborted), 32'd0);
        chk_eq("kill_done_clr", 32'(o_done), 32'd0);
        fin = 1'b1;
      end else begin
        rdy      = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
        tx_ready = rdy;
        start    = (acc < NBYTES - 1) ? 1'($urandom) : 1'b0;
        #1;
        exp_busy = (acc < NBYTES);
        busy_cnt += int'(o_busy);
        chk_eq("busy", 32'(o_busy), 32'(exp_busy));
        chk_eq("rf_we", 32'(o_rf_we), 32'(pipe_we & ~exp_busy));
        chk_eq("rf_a1", 32'(o_rf_a1), exp_busy ? 32'(acc / NB) : 32'(pipe_a1));
        if (prev_stall) begin
          chk_eq("stall_valid", 32'(o_tx_valid), 32'd1);
          chk_eq("stall_data", 32'(o_tx_data), 32'(prev_data));
        end
        if (last_acc_cyc >= 0 && cyc == last_acc_cyc + 1) begin
          chk_eq("done_pulse", 32'(o_done), 32'd1);
          if (chk_timing) chk_eq("done_cycle", 32'(cyc), 32'd193);
        end else if (last_acc_cyc >= 0 && cyc == last_acc_cyc + 2) begin
          chk_eq("done_clr", 32'(o_done), 32'd0);
          if (chk_timing) chk_eq("busy_cycles", 32'(busy_cnt), 32'd192);
          fin = 1'b1;
        end else begin
          chk_eq("done_early", 32'(o_done), 32'd0);
        end
        if (kill_mode != 0 && exp_busy && (acc / NB) == kill_reg && o_tx_valid) begin
          if (kill_mode == 1) pipe_halted = 1'b0;
          else reset = 1'b1;
          killed     = 1'b1;
          prev_stall = 1'b0;
        end else begin
          if (o_tx_valid && rdy) begin
            if (acc < NBYTES) begin
              chk_eq($sformatf("byte%0d", acc), 32'(o_tx_data), 32'(exp_q[acc]));
              got[acc] = o_tx_data;
            end else begin
              chk_eq("byte_count", 32'(acc + 1), 32'(NBYTES));
            end
            acc++;
            if (acc == NBYTES) last_acc_cyc = cyc;
          end
          prev_stall = o_tx_valid && !rdy;
          prev_data  = o_tx_data;
        end
      end
    end
    start = 1'b0;
    chk_eq("dump_finished", 32'(fin), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pipe_halted = 1'b0; pipe_a1 = AW'(19);
    pipe_a3 = '0; pipe_we = 1'b0; pipe_wd = '0; tx_ready = 1'b0; preload_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_eq("rst_busy", 32'(o_busy), 32'd0);
    chk_eq("rst_tx_valid", 32'(o_tx_valid), 32'd0);
    chk_eq("rst_tx_data0", 32'(o_tx_data), 32'd0);
    chk_eq("rst_done", 32'(o_done), 32'd0);
    chk_eq("rst_aborted0", 32'(o_aborted), 32'd0);
    chk_eq("rst_rf_a1", 32'(o_rf_a1), 32'd19);
    chk_eq("rst_rf_we0", 32'(o_rf_we), 32'd0);
    reset = 1'b0;
    idle_cycles(3);

    // Known pattern, tx_ready high: exact timing and the 0xDEADBEEF bytes.
    preload(1'b1);
    run_dump(1'b1, 0, 0, 0, 1'b1);
    chk_eq("reg5_b0", 32'(got[20]), 32'hDE);
    chk_eq("reg5_b1", 32'(got[21]), 32'hAD);
    chk_eq("reg5_b2", 32'(got[22]), 32'hBE);
    chk_eq("reg5_b3", 32'(got[23]), 32'hEF);

    // Same image with back-pressure.
    preload(1'b1);
    run_dump(1'b1, 1, 0, 0, 1'b0);
    idle_cycles(4);

    // Start before halt: pass-through while waiting, then a full dump from reg 0.
    preload(1'b0);
    pipe_halted = 1'b0;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pipe_a1 = AW'($urandom);
      #1;
      chk_eq("wait_rf_a1", 32'(o_rf_a1), 32'(pipe_a1));
      chk_eq("wait_busy", 32'(o_busy), 32'd0);
    end
    run_dump(1'b0, 0, 0, 0, 1'b1);

    // Halt lost during reg 7.
    preload(1'b0);
    run_dump(1'b1, 0, 1, 7, 1'b0);
    idle_cycles(3);

    // Reset mid-dump, then a clean dump.
    preload(1'b0);
    run_dump(1'b1, 1, 2, $urandom_range(3, 20), 1'b0);
    preload(1'b0);
    run_dump(1'b1, 0, 0, 0, 1'b1);

    // Random data with back-pressure.
    preload(1'b0);
    run_dump(1'b1, 1, 0, 0, 1'b0);
    idle_cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
